ctrl_pipe: RTL and testbench

Control-signal pipeline and hazard unit for the 5-stage RISC-V core. It sits downstream of the ID-stage control decoder and consumes its decoded bundle plus the branch-compare result. It carries the bundle through the EX, MEM and WB stage registers, inserts bubbles on load-use hazards, and raises the IF/ID flush for taken branches. It also exposes per-stage destination registers for the forwarding unit and counts retired instructions.

---
 rtl/ctrl_pipe.sv | 156 +++++++++++++++
 tb/tb_ctrl_pipe.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: control-signal pipeline and hazard unit for the 5-stage RISC-V core.
// Carries the decoded ID control bundle through the EX, MEM and WB stage registers.
// Inserts a bubble on a load-use hazard and raises the IF/ID flush for taken branches.
// Exposes each stage's destination register for forwarding, and counts retired instructions.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   ID_valid_i           ID holds a real instruction
//   MemWrite_i .. RDaddr_i  decoded control and register fields of the ID instruction
//   RegEqual_i           rs1 == rs2 compare result in ID
//   stall_o, flush_o     combinational hazard outputs (hold PC/IF-ID, clear IF/ID)
//   EX_*, MEM_*, WB_*    per-stage control and destination register
//   retire_cnt_o         count of instructions that completed WB (wraps)
module ctrl_pipe #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ID_valid_i,
  input  logic             MemWrite_i,
  input  logic             MemRead_i,
  input  logic             MemToReg_i,
  input  logic             ALUSrc_i,
  input  logic             RegWrite_i,
  input  logic             Branch_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             RegEqual_i,
  input  logic [4:0]       RS1addr_i,
  input  logic [4:0]       RS2addr_i,
  input  logic [4:0]       RDaddr_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic [1:0]       EX_ALUOp_o,
  output logic             EX_ALUSrc_o,
  output logic             EX_MemRead_o,
  output logic [4:0]       EX_RDaddr_o,
  output logic             MEM_MemRead_o,
  output logic             MEM_MemWrite_o,
  output logic             MEM_RegWrite_o,
  output logic             MEM_MemToReg_o,
  output logic [4:0]       MEM_RDaddr_o,
  output logic             WB_RegWrite_o,
  output logic             WB_MemToReg_o,
  output logic [4:0]       WB_RDaddr_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef struct packed {
    logic       valid;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic [4:0] rd;
  } wb_t;

  ex_t              ex_d, ex_q;
  mem_t             mem_d, mem_q;
  wb_t              wb_d, wb_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             stall;
  logic             rs_match;

  // Load-use hazard: the load in EX has not produced its data yet. x0 never hazards.
  always_comb begin
    rs_match = (ex_q.rd == RS1addr_i) | (ex_q.rd == RS2addr_i);
    stall    = ex_q.valid & ex_q.mem_read & (ex_q.rd != 5'd0) & ID_valid_i & rs_match;
  end

  assign stall_o = stall;
  // Stall wins: branch operands may come from the pending load.
  assign flush_o = ID_valid_i & Branch_i & RegEqual_i & ~stall;

  always_comb begin
    ex_d = '0;
    if (ID_valid_i && !stall) begin
      ex_d.valid      = 1'b1;
      ex_d.alu_op     = ALUOp_i;
      ex_d.alu_src    = ALUSrc_i;
      ex_d.mem_read   = MemRead_i;
      ex_d.mem_write  = MemWrite_i;
      ex_d.reg_write  = RegWrite_i;
      ex_d.mem_to_reg = MemToReg_i;
      ex_d.rd         = RDaddr_i;
    end

    // EX/MEM/WB always advance; a stall only holds the front end.
    mem_d            = '0;
    mem_d.valid      = ex_q.valid;
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.rd         = ex_q.rd;

    wb_d            = '0;
    wb_d.valid      = mem_q.valid;
    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.rd         = mem_q.rd;

    cnt_d = cnt_q;
    if (wb_q.valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    EX_ALUOp_o     = ex_q.alu_op & {2{ex_q.valid}};
    EX_ALUSrc_o    = ex_q.alu_src & ex_q.valid;
    EX_MemRead_o   = ex_q.mem_read & ex_q.valid;
    EX_RDaddr_o    = ex_q.rd & {5{ex_q.valid}};
    MEM_MemRead_o  = mem_q.mem_read & mem_q.valid;
    MEM_MemWrite_o = mem_q.mem_write & mem_q.valid;
    MEM_RegWrite_o = mem_q.reg_write & mem_q.valid;
    MEM_MemToReg_o = mem_q.mem_to_reg & mem_q.valid;
    MEM_RDaddr_o   = mem_q.rd & {5{mem_q.valid}};
    WB_RegWrite_o  = wb_q.reg_write & wb_q.valid;
    WB_MemToReg_o  = wb_q.mem_to_reg & wb_q.valid;
    WB_RDaddr_o    = wb_q.rd & {5{wb_q.valid}};
    retire_cnt_o   = cnt_q;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe: directed scenarios plus random traffic, checked against a
// history-queue reference model. A second instance with CNT_W = 3 checks counter wrap.
module tb_ctrl_pipe;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       id_valid, mem_write, mem_read, mem_to_reg, alu_src, reg_write, branch, reg_equal;
  logic [1:0] alu_op;
  logic [4:0] rs1, rs2, rd;

  logic        stall_o, flush_o, EX_ALUSrc_o, EX_MemRead_o;
  logic [1:0]  EX_ALUOp_o;
  logic [4:0]  EX_RDaddr_o, MEM_RDaddr_o, WB_RDaddr_o;
  logic        MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_MemToReg_o;
  logic        WB_RegWrite_o, WB_MemToReg_o;
  logic [31:0] retire_cnt_o;

  logic        stall_3, flush_3, EX_ALUSrc_3, EX_MemRead_3;
  logic [1:0]  EX_ALUOp_3;
  logic [4:0]  EX_RDaddr_3, MEM_RDaddr_3, WB_RDaddr_3;
  logic        MEM_MemRead_3, MEM_MemWrite_3, MEM_RegWrite_3, MEM_MemToReg_3;
  logic        WB_RegWrite_3, WB_MemToReg_3;
  logic [2:0]  retire_cnt_3;

  ctrl_pipe #(.CNT_W(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .ID_valid_i(id_valid),
    .MemWrite_i(mem_write), .MemRead_i(mem_read), .MemToReg_i(mem_to_reg),
    .ALUSrc_i(alu_src), .RegWrite_i(reg_write), .Branch_i(branch), .ALUOp_i(alu_op),
    .RegEqual_i(reg_equal), .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd),
    .stall_o(stall_o), .flush_o(flush_o),
    .EX_ALUOp_o(EX_ALUOp_o), .EX_ALUSrc_o(EX_ALUSrc_o), .EX_MemRead_o(EX_MemRead_o),
    .EX_RDaddr_o(EX_RDaddr_o),
    .MEM_MemRead_o(MEM_MemRead_o), .MEM_MemWrite_o(MEM_MemWrite_o),
    .MEM_RegWrite_o(MEM_RegWrite_o), .MEM_MemToReg_o(MEM_MemToReg_o),
    .MEM_RDaddr_o(MEM_RDaddr_o),
    .WB_RegWrite_o(WB_RegWrite_o), .WB_MemToReg_o(WB_MemToReg_o), .WB_RDaddr_o(WB_RDaddr_o),
    .retire_cnt_o(retire_cnt_o)
  );

  ctrl_pipe #(.CNT_W(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .ID_valid_i(id_valid),
    .MemWrite_i(mem_write), .MemRead_i(mem_read), .MemToReg_i(mem_to_reg),
    .ALUSrc_i(alu_src), .RegWrite_i(reg_write), .Branch_i(branch), .ALUOp_i(alu_op),
    .RegEqual_i(reg_equal), .RS1addr_i(rs1), .RS2addr_i(rs2), .RDaddr_i(rd),
    .stall_o(stall_3), .flush_o(flush_3),
    .EX_ALUOp_o(EX_ALUOp_3), .EX_ALUSrc_o(EX_ALUSrc_3), .EX_MemRead_o(EX_MemRead_3),
    .EX_RDaddr_o(EX_RDaddr_3),
    .MEM_MemRead_o(MEM_MemRead_3), .MEM_MemWrite_o(MEM_MemWrite_3),
    .MEM_RegWrite_o(MEM_RegWrite_3), .MEM_MemToReg_o(MEM_MemToReg_3),
    .MEM_RDaddr_o(MEM_RDaddr_3),
    .WB_RegWrite_o(WB_RegWrite_3), .WB_MemToReg_o(WB_MemToReg_3), .WB_RDaddr_o(WB_RDaddr_3),
    .retire_cnt_o(retire_cnt_3)
  );

  logic [26:0] obs_a, obs_b;
  assign obs_a = {stall_o, flush_o, EX_ALUOp_o, EX_ALUSrc_o, EX_MemRead_o, EX_RDaddr_o,
                  MEM_MemRead_o, MEM_MemWrite_o, MEM_RegWrite_o, MEM_MemToReg_o, MEM_RDaddr_o,
                  WB_RegWrite_o, WB_MemToReg_o, WB_RDaddr_o};
  assign obs_b = {stall_3, flush_3, EX_ALUOp_3, EX_ALUSrc_3, EX_MemRead_3, EX_RDaddr_3,
                  MEM_MemRead_3, MEM_MemWrite_3, MEM_RegWrite_3, MEM_MemToReg_3, MEM_RDaddr_3,
                  WB_RegWrite_3, WB_MemToReg_3, WB_RDaddr_3};

  // Reference model: the last three instructions accepted into the pipe, oldest first.
  // Index 0 is in WB, 1 in MEM, 2 in EX. A bubble is an all-zero record.
  typedef struct packed {
    logic       v;
    logic [1:0] aluop;
    logic       alusrc, memread, memwrite, regwrite, memtoreg;
    logic [4:0] rd;
  } instr_t;

  instr_t      hist[$];
  int unsigned retired;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    repeat (3) hist.push_back('0);
    retired = 0;
  endtask

  function automatic logic exp_stall();
    instr_t ex;
    ex = hist[2];
    return ex.v & ex.memread & (ex.rd != 5'd0) & id_valid & ((ex.rd == rs1) | (ex.rd == rs2));
  endfunction

  function automatic logic [26:0] exp_vec();
    instr_t ex, mem, wb;
    logic   s;
    ex  = hist[2];
    mem = hist[1];
    wb  = hist[0];
    s   = exp_stall();
    return {s, id_valid & branch & reg_equal & ~s, ex.aluop, ex.alusrc, ex.memread, ex.rd,
            mem.memread, mem.memwrite, mem.regwrite, mem.memtoreg, mem.rd,
            wb.regwrite, wb.memtoreg, wb.rd};
  endfunction

  task automatic drive(input logic v, input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic as, input logic br, input logic re,
                       input logic [1:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] d);
    id_valid = v; mem_read = mr; mem_write = mw; reg_write = rw; mem_to_reg = m2r;
    alu_src = as; branch = br; reg_equal = re; alu_op = op; rs1 = r1; rs2 = r2; rd = d;
  endtask

  task automatic bubble();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0);
  endtask

  // Called just after a negedge: let inputs settle, then compare everything to the model.
  task automatic settle();
    #1;
    chk("outputs", 32'(obs_a), 32'(exp_vec()));
    chk("outputs_w3", 32'(obs_b), 32'(exp_vec()));
    chk("retire_cnt", retire_cnt_o, retired);
    chk("retire_cnt_w3", 32'(retire_cnt_3), retired % 8);
  endtask

  task automatic step_clk();
    instr_t nb;
    nb = '0;
    if (id_valid && !exp_stall()) begin
      nb = '{v: 1'b1, aluop: alu_op, alusrc: alu_src, memread: mem_read,
             memwrite: mem_write, regwrite: reg_write, memtoreg: mem_to_reg, rd: rd};
    end
    @(posedge clk);
    if (hist[0].v) retired++;
    void'(hist.pop_front());
    hist.push_back(nb);
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    settle();
    chk("rst_wb_rd", 32'(WB_RDaddr_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bubble();
    #2;
    do_reset();

    // Load x5 then dependent add: one stall, one bubble, then the add proceeds.
    drive(1, 1, 0, 1, 1, 1, 0, 0, 2'd0, 5'd2, 5'd0, 5'd5); settle(); step_clk();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 5'd5, 5'd6, 5'd7); settle();
    chk("lu_stall", 32'(stall_o), 32'd1);
    step_clk();
    settle();
    chk("lu_bubble_rd", 32'(EX_RDaddr_o), 32'd0);
    chk("lu_bubble_mr", 32'(EX_MemRead_o), 32'd0);
    chk("lu_no_second_stall", 32'(stall_o), 32'd0);
    step_clk();
    bubble(); settle();
    chk("lu_add_ex_rd", 32'(EX_RDaddr_o), 32'd7);
    chk("lu_add_ex_op", 32'(EX_ALUOp_o), 32'd2);
    step_clk();
    settle();
    chk("lu_add_mem_rw", 32'(MEM_RegWrite_o), 32'd1);
    step_clk();

    // Load to x0 followed by a reader of x0: no stall, no bubble.
    drive(1, 1, 0, 1, 1, 1, 0, 0, 2'd0, 5'd3, 5'd0, 5'd0); settle(); step_clk();
    drive(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 5'd0, 5'd0, 5'd9); settle();
    chk("x0_no_stall", 32'(stall_o), 32'd0);
    step_clk();
    bubble(); settle();
    chk("x0_ex_rd", 32'(EX_RDaddr_o), 32'd9);
    step_clk();

    // Taken branch flushes; untaken does not; branch still flows with writes off.
    drive(1, 0, 0, 0, 0, 0, 1, 1, 2'd1, 5'd10, 5'd11, 5'd0); settle();
    chk("br_flush", 32'(flush_o), 32'd1);
    step_clk();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 2'd1, 5'd10, 5'd11, 5'd0); settle();
    chk("br_ex_op", 32'(EX_ALUOp_o), 32'd1);
    chk("br_no_flush_ne", 32'(flush_o), 32'd0);
    step_clk();
    bubble(); settle();
    chk("br_mem_rw", 32'(MEM_RegWrite_o), 32'd0);
    chk("br_mem_mw", 32'(MEM_MemWrite_o), 32'd0);
    step_clk();

    // Branch depending on a load: stall first, flush on re-evaluation.
    drive(1, 1, 0, 1, 1, 1, 0, 0, 2'd0, 5'd2, 5'd0, 5'd8); settle(); step_clk();
    drive(1, 0, 0, 0, 0, 0, 1, 1, 2'd1, 5'd1, 5'd8, 5'd0); settle();
    chk("brld_stall", 32'(stall_o), 32'd1);
    chk("brld_no_flush", 32'(flush_o), 32'd0);
    step_clk();
    settle();
    chk("brld_stall_drop", 32'(stall_o), 32'd0);
    chk("brld_flush", 32'(flush_o), 32'd1);
    step_clk();

    // Stream of four R-type writes to x1..x4.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 5'd20, 5'd21, 5'(i + 1));
      else bubble();
      settle();
      if (i >= 3 && i <= 6) chk("wb_seq", 32'(WB_RDaddr_o), 32'(i - 2));
      step_clk();
    end
    settle();
    chk("stream_cnt", retire_cnt_o, 32'd4);
    step_clk();

    // Reset in the middle of a stream.
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, 1, 0, 0, 0, 2'd2, 5'd20, 5'd21, 5'(i + 11));
      settle();
      step_clk();
    end
    do_reset();
    chk("rst_mid_cnt", retire_cnt_o, 32'd0);
    chk("rst_mid_ex", 32'(EX_RDaddr_o), 32'd0);

    // Nine retirements: the 3-bit counter wraps.
    for (int i = 0; i < 12; i++) begin
      if (i < 9) drive(1, 0, 0, 1, 0, 0, 0, 0, 2'd2, 5'd20, 5'd21, 5'((i % 7) + 1));
      else bubble();
      settle();
      if (i == 10) chk("w3_at7", 32'(retire_cnt_3), 32'd7);
      if (i == 11) chk("w3_wrap", 32'(retire_cnt_3), 32'd0);
      step_clk();
    end
    settle();
    chk("w3_after9", 32'(retire_cnt_3), 32'd1);
    chk("w32_after9", retire_cnt_o, 32'd9);
    step_clk();

    // Random traffic with small register numbers to provoke hazards, plus random resets.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        settle();
        step_clk();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
